core_local_intr: RTL and testbench

Machine-mode core-local interrupt source: a memory-mapped 64-bit `mtime` counter, a `mtimecmp` comparator and an `msip` software-interrupt bit, plus a synchronizer for the external interrupt line. It sits on the data-side Wishbone bus as a slave. It drives the `xint_meip`/`xint_mtip`/`xint_msip` lines consumed by the write-back stage's exception logic.

---
 rtl/core_local_intr_if.sv | 33 +++
 rtl/core_local_intr.sv | 143 ++++++++++++++
 tb/tb_core_local_intr.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_local_intr_if.sv
// core_local_intr_if
// Wishbone classic slave bus used by core_local_intr. Signal names are taken
// from the slave's point of view (_i driven by the master, _o by the slave).
//   wbs_addr_i  [31:0] byte address (bits [1:0] ignored)
//   wbs_dat_i   [31:0] write data
//   wbs_sel_i   [3:0]  byte enables for writes
//   wbs_we_i           1 = write
//   wbs_cyc_i          bus cycle
//   wbs_stb_i          strobe
//   wbs_dat_o   [31:0] read data, valid with ack
//   wbs_ack_o          transfer done, 1-cycle pulse
//   wbs_err_o          unmapped offset, 1-cycle pulse
interface core_local_intr_if;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport slave (
    input  wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport master (
    output wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/core_local_intr.sv
// core_local_intr
// Machine-mode core-local interrupt source: 64-bit mtime with prescaler,
// mtimecmp comparator, msip software bit and an external-interrupt synchronizer,
// exposed as a Wishbone slave.
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-low reset
//   wbs           Wishbone slave bus (core_local_intr_if.slave)
//   ext_irq_i     asynchronous external interrupt request (level)
//   xint_meip_o   machine external interrupt pending (synchronized ext_irq_i)
//   xint_mtip_o   machine timer interrupt pending (registered mtime >= mtimecmp)
//   xint_msip_o   machine software interrupt pending (msip bit 0)
// Register map (offset from BASE_ADDR): 0x00 msip, 0x08/0x0C mtimecmp lo/hi,
// 0x10/0x14 mtime lo/hi; 0x04, 0x18, 0x1C answer with err.
module core_local_intr #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  core_local_intr_if.slave wbs,
  input  logic             ext_irq_i,
  output logic             xint_meip_o,
  output logic             xint_mtip_o,
  output logic             xint_msip_o
);

  localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [15:0] r_presc;
  logic        r_mtip;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_in_window;
  logic        w_accept;
  logic        w_write;
  logic        w_mapped;
  logic        w_tick;
  logic [2:0]  w_off;
  logic [31:0] w_rdata;
  logic [63:0] w_mtime_d;
  logic [63:0] w_mtimecmp_d;
  logic        w_msip_d;
  logic [1:0]  w_unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign w_unused_addr = wbs.wbs_addr_i[1:0];
  assign w_in_window   = (wbs.wbs_addr_i[31:5] == BASE_ADDR[31:5]);
  // A new transfer is taken only while no response is on the bus, so a master
  // holding stb gets one beat every two cycles.
  assign w_accept      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack & ~r_err & w_in_window;
  assign w_write       = w_accept & wbs.wbs_we_i;
  assign w_off         = wbs.wbs_addr_i[4:2];
  assign w_tick        = (r_presc == TickLast);

  // Read mux from current register contents; unmapped offsets read zero.
  always_comb begin
    w_mapped = 1'b1;
    w_rdata  = '0;
    case (w_off)
      3'd0:    w_rdata = {31'd0, r_msip};
      3'd2:    w_rdata = r_mtimecmp[31:0];
      3'd3:    w_rdata = r_mtimecmp[63:32];
      3'd4:    w_rdata = r_mtime[31:0];
      3'd5:    w_rdata = r_mtime[63:32];
      default: w_mapped = 1'b0;
    endcase
  end

  always_comb begin
    w_mtime_d    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_mtimecmp_d = r_mtimecmp;
    w_msip_d     = r_msip;
    if (w_write) begin
      case (w_off)
        3'd0: if (wbs.wbs_sel_i[0]) w_msip_d = wbs.wbs_dat_i[0];
        3'd2: w_mtimecmp_d[31:0]  = merge_bytes(r_mtimecmp[31:0], wbs.wbs_dat_i,
                                                wbs.wbs_sel_i);
        3'd3: w_mtimecmp_d[63:32] = merge_bytes(r_mtimecmp[63:32], wbs.wbs_dat_i,
                                                wbs.wbs_sel_i);
        // A software write to mtime wins over a coincident tick; the increment
        // is dropped and the other half holds.
        3'd4: w_mtime_d = {r_mtime[63:32],
                           merge_bytes(r_mtime[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i)};
        3'd5: w_mtime_d = {merge_bytes(r_mtime[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i),
                           r_mtime[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_presc    <= '0;
      r_mtip     <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_mtime    <= w_mtime_d;
      r_mtimecmp <= w_mtimecmp_d;
      r_msip     <= w_msip_d;
      // Writes never reset the prescaler; it free-runs 0..TICK_DIV-1.
      r_presc    <= w_tick ? 16'd0 : (r_presc + 16'd1);
      r_mtip     <= (r_mtime >= r_mtimecmp);
      r_sync1    <= ext_irq_i;
      r_sync2    <= r_sync1;
      r_ack      <= w_accept & w_mapped;
      r_err      <= w_accept & ~w_mapped;
      r_rdata    <= w_accept ? w_rdata : 32'd0;
    end
  end

  assign wbs.wbs_dat_o = r_rdata;
  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_err_o = r_err;
  assign xint_meip_o   = r_sync2;
  assign xint_mtip_o   = r_mtip;
  assign xint_msip_o   = r_msip;

endmodule

// File: tb/tb_core_local_intr.sv
// tb_core_local_intr
// Self-checking bench for core_local_intr. A behavioural model tracks mtime
// as (value at last write) + (ticks since then), counting ticks arithmetically
// from the number of clock edges since reset.
module tb_core_local_intr;
  localparam logic [31:0] Base = 32'h0200_0000;
  localparam int unsigned Div  = 4;

  logic clk;
  logic rst_n;
  logic ext_irq;
  logic meip, mtip, msip;
  int   n_cmp = 0;
  int   n_bad = 0;

  core_local_intr_if bus ();

  core_local_intr #(
    .BASE_ADDR(Base),
    .TICK_DIV (Div)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .wbs        (bus),
    .ext_irq_i  (ext_irq),
    .xint_meip_o(meip),
    .xint_mtip_o(mtip),
    .xint_msip_o(msip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] m_edges, m_bedge, m_base, m_cmp, m_now;
  logic        m_msip, m_mtip, m_s1, m_s2, m_busy;
  logic [31:0] m_rd, m_rdata;
  logic        m_acc;
  logic [2:0]  m_off;

  function automatic logic [31:0] bytemerge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic bit is_mapped(input logic [2:0] off);
    return off inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
  endfunction

  // Ticks happen on edges whose index is a multiple of Div; a write at edge
  // m_bedge swallows the tick of that edge.
  assign m_now = m_base + (m_edges / 64'(Div)) - (m_bedge / 64'(Div));
  assign m_off = bus.wbs_addr_i[4:2];
  assign m_acc = bus.wbs_cyc_i & bus.wbs_stb_i & !m_busy &
                 ((bus.wbs_addr_i & 32'hFFFF_FFE0) == Base);

  always_comb begin
    m_rdata = 32'd0;
    case (m_off)
      3'd0: m_rdata = {31'd0, m_msip};
      3'd2: m_rdata = m_cmp[31:0];
      3'd3: m_rdata = m_cmp[63:32];
      3'd4: m_rdata = m_now[31:0];
      3'd5: m_rdata = m_now[63:32];
      default: m_rdata = 32'd0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= '0; m_bedge <= '0; m_base <= '0; m_cmp <= '1;
      m_msip <= 1'b0; m_mtip <= 1'b0; m_s1 <= 1'b0; m_s2 <= 1'b0;
      m_busy <= 1'b0; m_rd <= '0;
    end else begin
      m_edges <= m_edges + 64'd1;
      m_busy  <= m_acc;
      m_mtip  <= (m_now >= m_cmp);
      m_s1    <= ext_irq;
      m_s2    <= m_s1;
      if (m_acc) begin
        m_rd <= m_rdata;
        if (bus.wbs_we_i) begin
          case (m_off)
            3'd0: if (bus.wbs_sel_i[0]) m_msip <= bus.wbs_dat_i[0];
            3'd2: m_cmp[31:0]  <= bytemerge(m_cmp[31:0], bus.wbs_dat_i, bus.wbs_sel_i);
            3'd3: m_cmp[63:32] <= bytemerge(m_cmp[63:32], bus.wbs_dat_i, bus.wbs_sel_i);
            3'd4: begin
              m_base  <= {m_now[63:32], bytemerge(m_now[31:0], bus.wbs_dat_i, bus.wbs_sel_i)};
              m_bedge <= m_edges + 64'd1;
            end
            3'd5: begin
              m_base  <= {bytemerge(m_now[63:32], bus.wbs_dat_i, bus.wbs_sel_i), m_now[31:0]};
              m_bedge <= m_edges + 64'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- bus driver (no checking) ----------------
  logic [31:0] x_rdat;
  logic        x_ack, x_err, x_clean, x_mtip_ack, x_msip_ack, x_mtip_after;
  int          x_lat;

  task automatic bus_idle();
    bus.wbs_addr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '0;
    bus.wbs_we_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
  endtask

  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel);
    @(negedge clk);
    bus.wbs_addr_i = addr; bus.wbs_we_i = we; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    x_ack = 1'b0; x_err = 1'b0; x_rdat = '0; x_lat = 0; x_mtip_ack = mtip; x_msip_ack = msip;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o || bus.wbs_err_o) begin
        x_ack = bus.wbs_ack_o; x_err = bus.wbs_err_o; x_rdat = bus.wbs_dat_o; x_lat = i;
        x_mtip_ack = mtip; x_msip_ack = msip;
        break;
      end
    end
    bus_idle();
    @(negedge clk);
    x_clean = !bus.wbs_ack_o && !bus.wbs_err_o;
    x_mtip_after = mtip;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus_idle(); ext_irq = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({meip, mtip, msip, bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o} !== 36'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0",
                        {meip, mtip, msip, bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    wb_xfer(Base + 32'h10, 1'b0, '0, '0);
    n_cmp++;
    if (x_ack !== 1'b1 || x_lat != 1 || x_clean !== 1'b1) begin
      n_bad++; $display("FAIL reset_read_ack: got ack=%b lat=%0d clean=%b want 1/1/1",
                        x_ack, x_lat, x_clean);
    end
    n_cmp++;
    if (x_rdat !== m_rd || x_rdat > 32'd3) begin
      n_bad++; $display("FAIL reset_mtime_lo: got %h want %h", x_rdat, m_rd);
    end
    wb_xfer(Base + 32'h0C, 1'b0, '0, '0);
    n_cmp++;
    if (x_rdat !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL reset_mtimecmp_hi: got %h want ffffffff", x_rdat);
    end
    n_cmp++;
    if (mtip !== 1'b0) begin
      n_bad++; $display("FAIL reset_mtip: got %b want 0", mtip);
    end
  endtask

  task automatic test_mtip();
    int t_reach, t_rise;
    wb_xfer(Base + 32'h0C, 1'b1, 32'h0, 4'hF);
    wb_xfer(Base + 32'h08, 1'b1, 32'h20, 4'hF);
    t_reach = -1; t_rise = -1;
    for (int i = 0; i < 400 && t_rise < 0; i++) begin
      @(negedge clk);
      if (t_reach < 0 && m_now >= 64'h20) t_reach = i;
      if (t_rise < 0 && mtip === 1'b1) t_rise = i;
      n_cmp++;
      if (mtip !== m_mtip) begin
        n_bad++; $display("FAIL mtip_track: cycle %0d got %b want %b", i, mtip, m_mtip);
      end
    end
    n_cmp++;
    if (t_rise - t_reach != 1 || t_rise < 0) begin
      n_bad++; $display("FAIL mtip_rise_delay: got %0d want 1", t_rise - t_reach);
    end
    wb_xfer(Base + 32'h0C, 1'b1, 32'h1, 4'hF);
    n_cmp++;
    if (x_mtip_ack !== 1'b1 || x_mtip_after !== 1'b0) begin
      n_bad++; $display("FAIL mtip_clear: got ack-cycle=%b next=%b want 1/0",
                        x_mtip_ack, x_mtip_after);
    end
  endtask

  task automatic test_mtime_carry();
    wb_xfer(Base + 32'h14, 1'b1, 32'h0, 4'hF);
    wb_xfer(Base + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF);
    repeat (4) @(negedge clk);
    wb_xfer(Base + 32'h10, 1'b0, '0, '0);
    n_cmp++;
    if (x_rdat !== m_rd || x_rdat > 32'd3) begin
      n_bad++; $display("FAIL carry_lo: got %h want %h", x_rdat, m_rd);
    end
    wb_xfer(Base + 32'h14, 1'b0, '0, '0);
    n_cmp++;
    if (x_rdat !== 32'h1 || x_rdat !== m_rd) begin
      n_bad++; $display("FAIL carry_hi: got %h want 1", x_rdat);
    end
    // Line the write's accept edge up with a tick edge.
    while (((m_edges + 64'd2) % 64'(Div)) != 64'd0) @(negedge clk);
    wb_xfer(Base + 32'h10, 1'b1, 32'h5, 4'hF);
    wb_xfer(Base + 32'h10, 1'b0, '0, '0);
    n_cmp++;
    if (x_rdat !== 32'h5 || x_rdat !== m_rd) begin
      n_bad++; $display("FAIL tick_write_lo: got %h want 5", x_rdat);
    end
  endtask

  task automatic test_msip();
    wb_xfer(Base, 1'b1, 32'h1, 4'b0001);
    n_cmp++;
    if (x_msip_ack !== 1'b1) begin
      n_bad++; $display("FAIL msip_set: got %b want 1", x_msip_ack);
    end
    wb_xfer(Base, 1'b1, 32'hFFFF_FFFE, 4'b0001);
    n_cmp++;
    if (msip !== 1'b0) begin
      n_bad++; $display("FAIL msip_clear: got %b want 0", msip);
    end
    wb_xfer(Base, 1'b0, '0, '0);
    n_cmp++;
    if (x_rdat !== 32'h0) begin
      n_bad++; $display("FAIL msip_read: got %h want 0", x_rdat);
    end
    wb_xfer(Base, 1'b1, 32'hFFFF_FFFF, 4'b1110);
    n_cmp++;
    if (msip !== 1'b0 || m_msip !== 1'b0) begin
      n_bad++; $display("FAIL msip_sel_ignored: got %b want 0", msip);
    end
  endtask

  task automatic test_err();
    logic [31:0] offs [3];
    offs[0] = 32'h04; offs[1] = 32'h1C; offs[2] = 32'h18;
    for (int i = 0; i < 3; i++) begin
      wb_xfer(Base + offs[i], 1'(i != 1), $urandom, 4'hF);
      n_cmp++;
      if (x_err !== 1'b1 || x_ack !== 1'b0 || x_rdat !== 32'h0 || x_lat != 1 || !x_clean) begin
        n_bad++; $display("FAIL err_%0h: got err=%b ack=%b dat=%h lat=%0d clean=%b want 1/0/0/1/1",
                          offs[i], x_err, x_ack, x_rdat, x_lat, x_clean);
      end
    end
    wb_xfer(Base + 32'h08, 1'b0, '0, '0);
    n_cmp++;
    if (x_rdat !== m_rd || x_rdat !== 32'h20) begin
      n_bad++; $display("FAIL err_no_side_effect: got %h want %h", x_rdat, m_rd);
    end
    wb_xfer(Base + 32'h40, 1'b1, 32'h1, 4'hF);
    n_cmp++;
    if (x_ack !== 1'b0 || x_err !== 1'b0 || msip !== 1'b0) begin
      n_bad++; $display("FAIL out_of_window: got ack=%b err=%b msip=%b want 0/0/0",
                        x_ack, x_err, msip);
    end
  endtask

  task automatic test_meip();
    @(negedge clk);
    ext_irq = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (meip !== ((i >= 2 && i <= 4) ? 1'b1 : 1'b0) || meip !== m_s2) begin
        n_bad++; $display("FAIL meip_pulse: step %0d got %b want %b", i, meip, m_s2);
      end
      if (i == 3) ext_irq = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] map_offs [5];
    logic [31:0] off;
    map_offs[0] = 32'h00; map_offs[1] = 32'h08; map_offs[2] = 32'h0C;
    map_offs[3] = 32'h10; map_offs[4] = 32'h14;
    off = map_offs[$urandom_range(0, 4)];
    @(negedge clk);
    bus.wbs_addr_i = Base + off; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = '0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.wbs_ack_o !== ((i % 2 == 0) ? 1'b1 : 1'b0) || bus.wbs_err_o !== 1'b0) begin
        n_bad++; $display("FAIL b2b_ack: beat %0d got ack=%b err=%b", i,
                          bus.wbs_ack_o, bus.wbs_err_o);
      end
      if (bus.wbs_ack_o === 1'b1 && bus.wbs_dat_o !== m_rd) begin
        n_bad++; $display("FAIL b2b_data: beat %0d got %h want %h", i, bus.wbs_dat_o, m_rd);
      end
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic        we;
    logic [2:0]  off;
    bit          inwin;
    for (int i = 0; i < 60; i++) begin
      off   = 3'($urandom_range(0, 7));
      inwin = ($urandom_range(0, 7) != 0);
      addr  = inwin ? (Base + {27'd0, off, 2'b00}) : (Base + 32'h20 + {27'd0, off, 2'b00});
      we    = 1'($urandom_range(0, 1));
      wb_xfer(addr, we, $urandom, 4'($urandom_range(0, 15)));
      n_cmp++;
      if (x_ack !== (inwin && is_mapped(off)) || x_err !== (inwin && !is_mapped(off))) begin
        n_bad++; $display("FAIL rand_resp: addr %h got ack=%b err=%b", addr, x_ack, x_err);
      end
      if (inwin && !we && x_rdat !== m_rd) begin
        n_bad++; $display("FAIL rand_rdata: addr %h got %h want %h", addr, x_rdat, m_rd);
      end
      if (mtip !== m_mtip || msip !== m_msip) begin
        n_bad++; $display("FAIL rand_irq: got mtip=%b msip=%b want %b/%b",
                          mtip, msip, m_mtip, m_msip);
      end
    end
  endtask

  task automatic test_reset_mid();
    ext_irq = 1'b1;
    wb_xfer(Base, 1'b1, 32'h1, 4'h1);
    wb_xfer(Base + 32'h0C, 1'b1, 32'h0, 4'hF);
    wb_xfer(Base + 32'h08, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    n_cmp++;
    if ({meip, mtip, msip} !== 3'b111) begin
      n_bad++; $display("FAIL pre_reset_irqs: got %b want 111", {meip, mtip, msip});
    end
    bus.wbs_addr_i = Base + 32'h10; bus.wbs_we_i = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    @(posedge clk);
    #2;
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_ack: got %b want 1", bus.wbs_ack_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({meip, mtip, msip, bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o} !== 36'd0) begin
      n_bad++; $display("FAIL async_reset_outputs: got %h want 0",
                        {meip, mtip, msip, bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o});
    end
    @(negedge clk);
    ext_irq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_err_o !== 1'b0 || msip !== 1'b0) begin
        n_bad++; $display("FAIL stale_response: got ack=%b err=%b msip=%b want 0/0/0",
                          bus.wbs_ack_o, bus.wbs_err_o, msip);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mtip();
    test_mtime_carry();
    test_msip();
    test_err();
    test_meip();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no summary want summary");
    $fatal(1, "timeout");
  end

endmodule
